// File: rtl/accel_fifo_bridge_pkg.sv
// Shared sizing constants for the accelerator FIFO bridge and its integrators.
package accel_fifo_bridge_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam int unsigned DEFAULT_PTR_W = $clog2(DEFAULT_DEPTH);

    // Pointer width for a given depth; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/accel_fifo_bridge_sync_fifo.sv
// Single-clock FIFO with registered read data and reject strobes for error tracking.
module accel_fifo_bridge_sync_fifo
    import accel_fifo_bridge_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             rej_push,
    output logic             rej_pop
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q;
    logic             do_push, do_pop;

    // Flags come only from the registered count.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Acceptance is judged on the pre-edge count, so at empty a pop never sees the new word.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign rej_push = push && full;
    assign rej_pop  = pop && empty;
    assign dout     = dout_q;

    // Occupancy next state.
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, count and read data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                dout_q   <= mem[rd_ptr_q];
            end
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/accel_fifo_bridge.sv
// Router/accelerator bridge: one FIFO toward the accelerator, one back to the router,
// with sticky overflow/underflow flags and a read-valid strobe for the accelerator.
module accel_fifo_bridge
    import accel_fifo_bridge_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             put_req,
    input  logic             get_req,
    input  logic [WIDTH-1:0] fifo_data_in,
    output logic [WIDTH-1:0] fifo_data_out,
    output logic             to_acc_empty,
    output logic             to_acc_full,
    output logic             from_acc_empty,
    output logic             from_acc_full,
    input  logic             acc_rd_req,
    output logic [WIDTH-1:0] acc_rd_data,
    output logic             acc_rd_valid,
    input  logic             acc_wr_req,
    input  logic [WIDTH-1:0] acc_wr_data,
    output logic             overflow,
    output logic             underflow
);

    logic to_rej_push, to_rej_pop, from_rej_push, from_rej_pop;
    logic overflow_q, underflow_q, acc_rd_valid_q;

    accel_fifo_bridge_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_to_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (put_req),
        .pop      (acc_rd_req),
        .din      (fifo_data_in),
        .dout     (acc_rd_data),
        .empty    (to_acc_empty),
        .full     (to_acc_full),
        .rej_push (to_rej_push),
        .rej_pop  (to_rej_pop)
    );

    accel_fifo_bridge_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_from_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (acc_wr_req),
        .pop      (get_req),
        .din      (acc_wr_data),
        .dout     (fifo_data_out),
        .empty    (from_acc_empty),
        .full     (from_acc_full),
        .rej_push (from_rej_push),
        .rej_pop  (from_rej_pop)
    );

    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign acc_rd_valid = acc_rd_valid_q;

    // Sticky error flags and the one-cycle read-valid strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            acc_rd_valid_q <= 1'b0;
        end else begin
            overflow_q     <= overflow_q | to_rej_push | from_rej_push;
            underflow_q    <= underflow_q | to_rej_pop | from_rej_pop;
            acc_rd_valid_q <= acc_rd_req && !to_acc_empty;
        end
    end

endmodule

// File: tb/tb_accel_fifo_bridge.sv
// Bench for accel_fifo_bridge: directed scenarios plus random traffic against a queue model.
module tb_accel_fifo_bridge;

    localparam int W = 32;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         put_req, get_req, acc_rd_req, acc_wr_req;
    logic [W-1:0] fifo_data_in, acc_wr_data;
    logic [W-1:0] fifo_data_out, acc_rd_data;
    logic         to_acc_empty, to_acc_full, from_acc_empty, from_acc_full;
    logic         acc_rd_valid, overflow, underflow;

    accel_fifo_bridge #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .put_req        (put_req),
        .get_req        (get_req),
        .fifo_data_in   (fifo_data_in),
        .fifo_data_out  (fifo_data_out),
        .to_acc_empty   (to_acc_empty),
        .to_acc_full    (to_acc_full),
        .from_acc_empty (from_acc_empty),
        .from_acc_full  (from_acc_full),
        .acc_rd_req     (acc_rd_req),
        .acc_rd_data    (acc_rd_data),
        .acc_rd_valid   (acc_rd_valid),
        .acc_wr_req     (acc_wr_req),
        .acc_wr_data    (acc_wr_data),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: plain queues plus the last word handed out on each side.
    logic [W-1:0] to_q[$];
    logic [W-1:0] from_q[$];
    logic [W-1:0] m_fifo_out, m_acc_rd;
    logic         m_valid, m_ovf, m_unf;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        to_q.delete();
        from_q.delete();
        m_fifo_out = '0;
        m_acc_rd   = '0;
        m_valid    = 1'b0;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".acc_rd_data"}, acc_rd_data, m_acc_rd);
        check_eq({tag, ".acc_rd_valid"}, acc_rd_valid, m_valid);
        check_eq({tag, ".fifo_data_out"}, fifo_data_out, m_fifo_out);
        check_eq({tag, ".to_empty"}, to_acc_empty, to_q.size() == 0);
        check_eq({tag, ".to_full"}, to_acc_full, to_q.size() == D);
        check_eq({tag, ".from_empty"}, from_acc_empty, from_q.size() == 0);
        check_eq({tag, ".from_full"}, from_acc_full, from_q.size() == D);
        check_eq({tag, ".overflow"}, overflow, m_ovf);
        check_eq({tag, ".underflow"}, underflow, m_unf);
    endtask

    // One clock: drive requests, let the edge happen, advance the model, check outputs.
    task automatic step(input logic put, input logic get, input logic rd, input logic wr,
                        input logic [W-1:0] pdata, input logic [W-1:0] wdata,
                        input string tag);
        bit to_push, to_pop, fr_push, fr_pop;
        put_req      = put;
        get_req      = get;
        acc_rd_req   = rd;
        acc_wr_req   = wr;
        fifo_data_in = pdata;
        acc_wr_data  = wdata;
        to_push = put && (to_q.size() < D);
        to_pop  = rd && (to_q.size() > 0);
        fr_push = wr && (from_q.size() < D);
        fr_pop  = get && (from_q.size() > 0);
        @(posedge clk);
        m_valid = to_pop;
        if (to_pop) m_acc_rd = to_q.pop_front();
        if (to_push) to_q.push_back(pdata);
        if (fr_pop) m_fifo_out = from_q.pop_front();
        if (fr_push) from_q.push_back(wdata);
        if ((put && !to_push) || (wr && !fr_push)) m_ovf = 1'b1;
        if ((rd && !to_pop) || (get && !fr_pop)) m_unf = 1'b1;
        #1;
        put_req    = 1'b0;
        get_req    = 1'b0;
        acc_rd_req = 1'b0;
        acc_wr_req = 1'b0;
        check_all(tag);
    endtask

    // Reset pulse placed between clock edges; outputs must clear without an edge.
    task automatic mid_reset(input string tag);
        #2 reset = 1'b0;
        #1 model_reset();
        check_all(tag);
        #2 reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        put_req      = 1'b0;
        get_req      = 1'b0;
        acc_rd_req   = 1'b0;
        acc_wr_req   = 1'b0;
        fifo_data_in = '0;
        acc_wr_data  = '0;
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b1;

        // Fill TO, then overflow it.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, W'(i), '0, "fill");
        check_eq("to_full_after_8", to_acc_full, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h99, '0, "put9");
        check_eq("overflow_on_9th", overflow, 1'b1);

        // Drain TO in order.
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, "drain");
            check_eq("drain_order", acc_rd_data, 64'(i));
            check_eq("drain_valid", acc_rd_valid, 1'b1);
        end
        check_eq("to_empty_after_drain", to_acc_empty, 1'b1);

        // FROM single word round trip.
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, 32'hA5A5_A5A5, "wr_a5");
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, "get_a5");
        check_eq("a5_out", fifo_data_out, 32'hA5A5_A5A5);
        check_eq("a5_from_empty", from_acc_empty, 1'b1);

        // Steady state at count 1 with simultaneous push and pop; start with clean flags.
        mid_reset("rst_a");
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, 32'h100, "pre_steady");
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, '0, 32'h200 + W'(i), "steady");
            check_eq("steady_data", fifo_data_out, (i == 0) ? 64'h100 : 64'h200 + 64'(i - 1));
        end
        check_eq("steady_no_ovf", overflow, 1'b0);
        check_eq("steady_no_unf", underflow, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, "steady_last");

        // Underflow on empty FROM; data output must hold.
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, "unf");
        check_eq("unf_flag", underflow, 1'b1);
        check_eq("unf_hold", fifo_data_out, 32'h200 + 32'd19);

        // Push/pop pairs that wrap the TO pointers.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'hC000 + W'(i), '0, "wrap_put");
            step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, "wrap_rd");
        end

        // Mid-clock reset with five words buffered, then a fresh word must come back.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'hD0 + W'(i), '0, "pre_rst");
        mid_reset("rst_b");
        check_eq("rst_b_to_empty", to_acc_empty, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, '0, "post_rst_put");
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, "post_rst_rd");
        check_eq("post_rst_word", acc_rd_data, 32'h1234_5678);

        // Random traffic, including occasional simultaneous router requests.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 45,
                 $urandom, $urandom, "rand");
            if (i == 200) mid_reset("rst_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
